// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sync polarity type and the timing-stage record
// carried down the output alignment pipe.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Position fields are sized for the largest supported raster; tops truncate.
  localparam int unsigned POS_W = 16;

  typedef enum logic {
    ACTIVE_LOW  = 1'b0,
    ACTIVE_HIGH = 1'b1
  } sync_pol_t;

  typedef struct packed {
    logic [POS_W-1:0] dot;
    logic [POS_W-1:0] line;
    logic             vis;
    logic             hs;
    logic             vs;
    logic             fs;
  } tstage_t;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_scan_gen_wrap_counter.sv
// Modulo-(MAX+1) counter; carry_o flags the increment that wraps MAX -> 0.
module wrap_counter #(
  parameter  int unsigned MAX = 1,
  localparam int unsigned W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         carry_o
);

  localparam logic [W-1:0] TOP = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  assign carry_o = inc_i && (cnt_q == TOP);
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = carry_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster generator: fetch-position counters drive the VRAM address, and the
// decoded timing is delayed by the read latency so pins line up with VRAM data.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter  int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter  int unsigned H_FP     = DEF_H_FP,
  parameter  int unsigned H_SYNC   = DEF_H_SYNC,
  parameter  int unsigned H_BP     = DEF_H_BP,
  parameter  int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter  int unsigned V_FP     = DEF_V_FP,
  parameter  int unsigned V_SYNC   = DEF_V_SYNC,
  parameter  int unsigned V_BP     = DEF_V_BP,
  parameter  int unsigned CLK_DIV  = 4,
  parameter  sync_pol_t   HS_POL   = ACTIVE_LOW,
  parameter  sync_pol_t   VS_POL   = ACTIVE_LOW,
  parameter  int unsigned PIPE     = 2,
  parameter  int unsigned ADDR_W   = 19,
  localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned DOT_W    = $clog2(H_TOTAL),
  localparam int unsigned LINE_W   = $clog2(V_TOTAL)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  output logic              pix_stb_o,
  output logic [ADDR_W-1:0] raddr_o,
  output logic [DOT_W-1:0]  dot_counter_o,
  output logic [LINE_W-1:0] scanline_counter_o,
  output logic              active_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              frame_start_o
);

  // PIPE=0 still keeps one register so outputs are glitch-free.
  localparam int unsigned STAGES = (PIPE == 0) ? 1 : PIPE;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DOT_W-1:0]  H_VIS_END = DOT_W'(H_ACTIVE);
  localparam logic [DOT_W-1:0]  HS_BEG    = DOT_W'(H_ACTIVE + H_FP);
  localparam logic [DOT_W-1:0]  HS_END    = DOT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [LINE_W-1:0] V_VIS_END = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W-1:0] VS_BEG    = LINE_W'(V_ACTIVE + V_FP);
  localparam logic [LINE_W-1:0] VS_END    = LINE_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic              HS_ON     = logic'(HS_POL);
  localparam logic              VS_ON     = logic'(VS_POL);
  localparam tstage_t RST_STAGE = '{dot: '0, line: '0, vis: 1'b0,
                                    hs: ~HS_ON, vs: ~VS_ON, fs: 1'b0};

  logic [DIV_W-1:0]  div_q, div_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DOT_W-1:0]  fdot;
  logic [LINE_W-1:0] fline;
  logic              pix_stb, dot_wrap, frame_wrap;
  tstage_t           cur;
  tstage_t           pipe_q [STAGES];
  tstage_t           last;
  logic              unused_hi;

  assign pix_stb = en_i & rst_n_i & (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en_i) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  wrap_counter #(.MAX(H_TOTAL - 1)) u_fdot (
    .clk_i   (clk_i),
    .clr_i   (~rst_n_i),
    .inc_i   (pix_stb),
    .cnt_o   (fdot),
    .carry_o (dot_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL - 1)) u_fline (
    .clk_i   (clk_i),
    .clr_i   (~rst_n_i),
    .inc_i   (dot_wrap),
    .cnt_o   (fline),
    .carry_o (frame_wrap)
  );

  always_comb begin
    cur      = '0;
    cur.dot  = POS_W'(fdot);
    cur.line = POS_W'(fline);
    cur.vis  = (fdot < H_VIS_END) && (fline < V_VIS_END);
    cur.hs   = ((fdot >= HS_BEG) && (fdot < HS_END)) ? HS_ON : ~HS_ON;
    cur.vs   = ((fline >= VS_BEG) && (fline < VS_END)) ? VS_ON : ~VS_ON;
    cur.fs   = (fdot == '0) && (fline == '0);
  end

  // Address follows the fetch position; a frame wrap wins over the visible increment.
  always_comb begin
    raddr_d = raddr_q;
    if (frame_wrap)             raddr_d = '0;
    else if (pix_stb && cur.vis) raddr_d = raddr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q   <= '0;
      raddr_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) pipe_q[k] <= RST_STAGE;
    end else begin
      div_q   <= div_d;
      raddr_q <= raddr_d;
      if (pix_stb) begin
        pipe_q[0] <= cur;
        for (int k = 1; k < int'(STAGES); k++) pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign last               = pipe_q[STAGES-1];
  assign pix_stb_o          = pix_stb;
  assign raddr_o            = raddr_q;
  assign dot_counter_o      = last.dot[DOT_W-1:0];
  assign scanline_counter_o = last.line[LINE_W-1:0];
  assign active_o           = last.vis;
  assign hsync_o            = last.hs;
  assign vsync_o            = last.vs;
  assign frame_start_o      = last.fs & pix_stb;
  assign unused_hi          = (|(last.dot >> DOT_W)) | (|(last.line >> LINE_W));

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench: default 640x480 instance and a tiny override instance, both compared
// every clock against a strobe-count reference model of the raster.
module tb_vga_scan_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic        pix_a, act_a, hs_a, vs_a, fs_a;
  logic [18:0] raddr_a;
  logic [9:0]  dot_a, line_a;
  logic        pix_b, act_b, hs_b, vs_b, fs_b;
  logic [5:0]  raddr_b;
  logic [3:0]  dot_b;
  logic [2:0]  line_b;

  vga_scan_gen u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pix_stb_o(pix_a), .raddr_o(raddr_a),
    .dot_counter_o(dot_a), .scanline_counter_o(line_a), .active_o(act_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .frame_start_o(fs_a)
  );

  vga_scan_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .CLK_DIV(1), .HS_POL(vga_pkg::ACTIVE_HIGH), .VS_POL(vga_pkg::ACTIVE_LOW),
    .PIPE(0), .ADDR_W(6)
  ) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pix_stb_o(pix_b), .raddr_o(raddr_b),
    .dot_counter_o(dot_b), .scanline_counter_o(line_b), .active_o(act_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .frame_start_o(fs_b)
  );

  typedef struct {
    int raddr; int dot; int line; int act; int hs; int vs; int fs;
  } exp_t;

  int   n_cmp = 0, n_fail = 0;
  int   ecnt = 0, ma = 0, mb = 0;
  int   hs_cnt = 0, act_cnt = 0;
  bit   count_line0 = 1'b0;
  logic v1 = 1'b0, v2 = 1'b0;

  // Expected state after m pixel strobes since reset, from raster arithmetic.
  function automatic exp_t ref_at(input int m, input int ha, input int hf, input int hw,
                                  input int hb, input int va, input int vf, input int vw,
                                  input int vb, input int pipe, input int hp, input int vp);
    exp_t e;
    int ht, vt, fr, p, l, d, j;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    fr = ht * vt;
    p  = m % fr;
    l  = p / ht;
    d  = p % ht;
    e.raddr = (l < va) ? l * ha + ((d < ha) ? d : ha) : va * ha;
    j = m - ((pipe == 0) ? 1 : pipe);
    if (j < 0) begin
      e.dot = 0; e.line = 0; e.act = 0; e.hs = 1 - hp; e.vs = 1 - vp; e.fs = 0;
    end else begin
      p = j % fr;
      l = p / ht;
      d = p % ht;
      e.dot  = d;
      e.line = l;
      e.act  = (d < ha && l < va) ? 1 : 0;
      e.hs   = (d >= ha + hf && d < ha + hf + hw) ? hp : 1 - hp;
      e.vs   = (l >= va + vf && l < va + vf + vw) ? vp : 1 - vp;
      e.fs   = (p == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, then advance the model.
  task automatic step(input logic en_v, input logic rst_v);
    exp_t ea, eb;
    logic sa, sb;
    logic ra0;
    @(negedge clk);
    en    = en_v;
    rst_n = rst_v;
    #1;
    sa = en_v && rst_v && (ecnt % 4 == 3);
    sb = en_v && rst_v;
    ea = ref_at(ma, 640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 0);
    eb = ref_at(mb, 8, 1, 2, 1, 4, 1, 1, 1, 0, 1, 0);
    chk("a.pix_stb", pix_a, sa);
    chk("a.raddr", raddr_a, ea.raddr);
    chk("a.dot", dot_a, ea.dot);
    chk("a.line", line_a, ea.line);
    chk("a.active", act_a, ea.act);
    chk("a.hsync", hs_a, ea.hs);
    chk("a.vsync", vs_a, ea.vs);
    chk("a.frame_start", fs_a, (ea.fs != 0) && sa);
    chk("b.pix_stb", pix_b, sb);
    chk("b.raddr", raddr_b, eb.raddr);
    chk("b.dot", dot_b, eb.dot);
    chk("b.line", line_b, eb.line);
    chk("b.active", act_b, eb.act);
    chk("b.hsync", hs_b, eb.hs);
    chk("b.vsync", vs_b, eb.vs);
    chk("b.frame_start", fs_b, (eb.fs != 0) && sb);
    if (act_a === 1'b1) chk("a.vram_align", v2, dot_a[0]);
    if (count_line0 && pix_a && line_a == 10'd0) begin
      hs_cnt  += int'(!hs_a);
      act_cnt += int'(act_a);
    end
    ra0 = raddr_a[0];
    @(posedge clk);
    if (!rst_v) begin
      ecnt = 0; ma = 0; mb = 0; v1 = 1'b0; v2 = 1'b0;
    end else if (en_v) begin
      if (sa) begin
        v2 = v1;
        v1 = ra0;
        ma++;
      end
      if (sb) mb++;
      ecnt++;
    end
  endtask

  initial begin
    en    = 1'b0;
    rst_n = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    count_line0 = 1'b1;
    for (int i = 0; i < 5000 && ma < 302 && n_fail < 30; i++) step(1'b1, 1'b1);
    chk("a.reach_dot300", ma >= 302, 1);
    for (int i = 0; i < 37 && n_fail < 30; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 8000 && ma < 1610 && n_fail < 30; i++) step(1'b1, 1'b1);
    count_line0 = 1'b0;
    chk("a.reach_line2", ma >= 1610, 1);
    chk("a.hsync_low_strobes_line0", hs_cnt, 96);
    chk("a.active_strobes_line0", act_cnt, 640);

    for (int i = 0; i < 2500 && n_fail < 30; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);

    for (int i = 0; i < 50 && n_fail < 30; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 300 && n_fail < 30; i++) step(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
Parametrised successor to the fixed text_counters dot/scanline counter. It generates VGA raster timing from the system clock: pixel strobe, dot/scanline position, hsync/vsync, active-video flag and frame-start pulse. It also produces a linear framebuffer read address for the VRAM read port. The address runs PIPE pixels ahead of the displayed position, so VRAM read data lines up with the delayed timing outputs. It sits between the system clock domain and VRAM raddr / VGA pins.

Parameters:
H_ACTIVE, 640, visible dots per line
H_FP, 16, horizontal front porch (dots)
H_SYNC, 96, hsync width (dots)
H_BP, 48, horizontal back porch (dots)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 4, system clocks per pixel (>=1; 100 MHz -> 25 MHz)
HS_POL, 0, hsync asserted level
VS_POL, 0, vsync asserted level
PIPE, 2, read-latency compensation in pixel strobes (0..4)
ADDR_W, 19, raddr width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
en  in  1  run enable; 0 freezes all state
pix_stb  out  1  one-clk pulse per pixel period
raddr  out  ADDR_W  VRAM read address (fetch position)
dot_counter  out  DOT_W  displayed dot, DOT_W=$clog2(H_TOTAL)
scanline_counter  out  LINE_W  displayed line, LINE_W=$clog2(V_TOTAL)
active  out  1  displayed position in visible region
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
frame_start  out  1  pulse on pix_stb that displays (0,0)

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: divider=0; fetch counters (0,0); pix_stb=0; raddr=0; dot_counter=0; scanline_counter=0; active=0; frame_start=0; hsync=!HS_POL; vsync=!VS_POL.
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the vertical equivalent.
- Divider: counts 0..CLK_DIV-1 while en=1. pix_stb=1 in the clk where divider==CLK_DIV-1. If CLK_DIV=1, pix_stb=en every clk.
- Fetch counters (fdot, fline):
  - Advance only on pix_stb.
  - fdot wraps H_TOTAL-1 -> 0 and increments fline.
  - fline wraps V_TOTAL-1 -> 0 on that same strobe.
- raddr:
  - Increments by 1 on each pix_stb where the current fetch position is visible (fdot<H_ACTIVE and fline<V_ACTIVE).
  - Resets to 0 on the strobe where the fetch position wraps to (0,0). It therefore presents 0 while fetching pixel (0,0).
  - Holds its value during blanking.
  - Incremental only; no multiplier.
- Timing decode from fetch position (combinational, per strobe):
  - vis = fetch position visible.
  - hs = HS_POL when H_ACTIVE+H_FP <= fdot < H_ACTIVE+H_FP+H_SYNC.
  - vs = VS_POL when V_ACTIVE+V_FP <= fline < V_ACTIVE+V_FP+V_SYNC.
  - fs = (fdot==0 && fline==0).
- Output alignment:
  - {fdot, fline, vis, hs, vs, fs} pass through a PIPE-deep shift register that advances only on pix_stb.
  - Stage outputs drive dot_counter, scanline_counter, active, hsync, vsync.
  - frame_start = last-stage fs AND pix_stb (one clk wide).
  - PIPE=0: outputs are registered fetch values updated on the same pix_stb, i.e. one clk after the fetch position.
- en=0: divider, counters, raddr and pipe all hold; pix_stb=0; frame_start=0; sync levels hold. Resuming continues with no skipped or repeated pixels.
- Reset mid-frame: all state returns to reset values on the next clk edge. The first strobe after release fetches (0,0).
- Simultaneous line wrap and frame wrap on one strobe: a single update, fline->0 and raddr->0.

Decomposition:
- vga_pkg holds:
  - default 640x480@60 timing constants;
  - derived H_TOTAL/V_TOTAL functions;
  - the sync_pol_t enum (ACTIVE_LOW=0, ACTIVE_HIGH=1);
  - a timing-stage struct {dot, line, vis, hs, vs, fs}.
- One sub-module, wrap_counter: parametrised MAX, with inc/clr inputs and a carry output. It is instantiated twice, for fdot (inc=pix_stb) and for fline (inc=fdot carry).

Test Plan:
- Reset released, en=1, defaults -> pix_stb every 4th clk; first raddr=0. After PIPE=2 strobes, dot_counter=0, scanline_counter=0, active=1, frame_start pulses once.
- Run one full line -> hsync=0 exactly for displayed dots 656..751 (96 strobes); active=0 for dots 640..799; dot_counter wraps 799->0; scanline_counter 0->1.
- Run one full frame -> vsync=0 for lines 490..491. raddr reaches 307199 at the last visible fetch, holds through blanking, then returns to 0. frame_start period = 800*525*4 = 1,680,000 clk.
- Alignment: PIPE=2 with a 2-stage-latency VRAM model holding data=addr[0] -> on every active=1 cycle the returned data matches dot_counter[0] parity.
- en deasserted for 37 clk mid-line at dot 300 -> all outputs frozen. After resume, the next strobe shows dot 301 and raddr continues by +1.
- Overrides H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=1, HS_POL=1, PIPE=0 -> hsync=1 at dots 9..10. Frame = 12*7 = 84 clk. raddr sweeps 0..31. Rerun with rst_n=0 mid-frame -> reset values on the next edge.
